axi_ram: RTL

AXI_RAM -- requirements
Module: axi_ram

---
 rtl/axi_ram.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/axi_ram.sv
// axi_ram: AXI4 slave backed by an internal word RAM.
//   - INCR bursts only, full-width beats, one transaction in flight.
//   - Write and read address channels share one FSM (IDLE/WRITE/WRESP/READ).
//   - When both address channels request at once, the channel that was not
//     granted last wins (write wins first after reset).
//   - Beats whose word index falls outside DEPTH write nothing, read as zero
//     and report SLVERR. A w_last that disagrees with aw_len also gives SLVERR.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   aw_id/addr/len/valid, aw_ready    write address channel
//   w_data/strb/last/valid, w_ready   write data channel
//   b_id/resp/valid, b_ready          write response channel
//   ar_id/addr/len/valid, ar_ready    read address channel
//   r_id/data/resp/last/valid, r_ready read data channel
module axi_ram #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   aw_id,
    input  logic [ADDR_WIDTH-1:0] aw_addr,
    input  logic [7:0]            aw_len,
    input  logic                  aw_valid,
    output logic                  aw_ready,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [STRB_WIDTH-1:0] w_strb,
    input  logic                  w_last,
    input  logic                  w_valid,
    output logic                  w_ready,
    output logic [ID_WIDTH-1:0]   b_id,
    output logic [1:0]            b_resp,
    output logic                  b_valid,
    input  logic                  b_ready,
    input  logic [ID_WIDTH-1:0]   ar_id,
    input  logic [ADDR_WIDTH-1:0] ar_addr,
    input  logic [7:0]            ar_len,
    input  logic                  ar_valid,
    output logic                  ar_ready,
    output logic [ID_WIDTH-1:0]   r_id,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic [1:0]            r_resp,
    output logic                  r_last,
    output logic                  r_valid,
    input  logic                  r_ready
);

    localparam int LG = $clog2(STRB_WIDTH);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] WORD_LIMIT = ADDR_WIDTH'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_WRESP = 2'd2;
    localparam logic [1:0] S_READ  = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [1:0]            r_state;
    logic                  r_prio_rd;   // 1: read wins the next simultaneous request
    logic [ADDR_WIDTH-1:0] r_addr;      // address of the next beat to transfer
    logic [7:0]            r_len;
    logic [7:0]            r_cnt;       // index of the current beat
    logic                  r_werr;      // sticky write error

    logic                  w_idle;
    logic                  w_grant_wr;
    logic                  w_aw_hs;
    logic                  w_ar_hs;
    logic                  w_w_hs;
    logic                  w_last_beat;
    logic                  w_werr_nxt;
    logic [ADDR_WIDTH-1:0] w_beat_addr;
    logic [ADDR_WIDTH-1:0] w_beat_idx;
    logic                  w_beat_ok;
    logic [IW-1:0]         w_mem_idx;
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign w_idle     = (r_state == S_IDLE);
    assign w_grant_wr = aw_valid && (!ar_valid || !r_prio_rd);
    assign aw_ready   = w_idle && !rst && w_grant_wr;
    assign ar_ready   = w_idle && !rst && ar_valid && !w_grant_wr;
    assign w_ready    = (r_state == S_WRITE);

    assign w_aw_hs = aw_valid && aw_ready;
    assign w_ar_hs = ar_valid && ar_ready;
    assign w_w_hs  = w_valid && w_ready;

    assign w_last_beat = (r_cnt == r_len);

    // In IDLE the first read beat is fetched straight from ar_addr so that
    // r_valid can rise the cycle after the AR handshake.
    assign w_beat_addr = w_idle ? ar_addr : r_addr;
    assign w_beat_idx  = w_beat_addr >> LG;
    assign w_beat_ok   = (w_beat_idx < WORD_LIMIT);
    assign w_mem_idx   = w_beat_idx[IW-1:0];
    assign w_rd_word   = w_beat_ok ? r_mem[w_mem_idx] : '0;

    assign w_werr_nxt = r_werr || (w_last != w_last_beat) || !w_beat_ok;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_w_hs && w_beat_ok) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (w_strb[b]) r_mem[w_mem_idx][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_prio_rd <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_werr    <= 1'b0;
            b_id      <= '0;
            b_resp    <= RESP_OKAY;
            b_valid   <= 1'b0;
            r_id      <= '0;
            r_data    <= '0;
            r_resp    <= RESP_OKAY;
            r_last    <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_aw_hs) begin
                        b_id      <= aw_id;
                        r_addr    <= aw_addr;
                        r_len     <= aw_len;
                        r_cnt     <= '0;
                        r_werr    <= 1'b0;
                        r_prio_rd <= 1'b1;
                        r_state   <= S_WRITE;
                    end else if (w_ar_hs) begin
                        r_id      <= ar_id;
                        r_addr    <= ar_addr + ADDR_STEP;
                        r_len     <= ar_len;
                        r_cnt     <= '0;
                        r_prio_rd <= 1'b0;
                        r_data    <= w_rd_word;
                        r_resp    <= w_beat_ok ? RESP_OKAY : RESP_SLVERR;
                        r_last    <= (ar_len == 8'd0);
                        r_valid   <= 1'b1;
                        r_state   <= S_READ;
                    end
                end
                S_WRITE: begin
                    if (w_w_hs) begin
                        r_addr <= r_addr + ADDR_STEP;
                        r_cnt  <= r_cnt + 8'd1;
                        r_werr <= w_werr_nxt;
                        if (w_last_beat) begin
                            b_resp  <= w_werr_nxt ? RESP_SLVERR : RESP_OKAY;
                            b_valid <= 1'b1;
                            r_state <= S_WRESP;
                        end
                    end
                end
                S_WRESP: begin
                    if (b_ready) begin
                        b_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_READ: begin
                    // Outputs only move on a handshake, so they hold under back-pressure.
                    if (r_ready) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_data <= w_rd_word;
                            r_resp <= w_beat_ok ? RESP_OKAY : RESP_SLVERR;
                            r_last <= ((r_cnt + 8'd1) == r_len);
                            r_cnt  <= r_cnt + 8'd1;
                            r_addr <= r_addr + ADDR_STEP;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
